swivm_mem_arbiter: RTL and testbench

- Two-requester arbiter for the single SwiVM memory port (16-bit address, 32-bit data, byte/half/word size, active-low write enable).
- Port 0 is the CPU. Port 1 is a secondary master (program loader / debug DMA).
- The arbiter sequences each access as a two-cycle memory transaction, grants round-robin, and returns read data with a one-cycle ack pulse.
- It sits between the masters and the memory module.

---
 rtl/swivm_mem_arbiter_if.sv | 46 ++++
 rtl/swivm_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_swivm_mem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/swivm_mem_arbiter_if.sv
// Bundle of both requester ports and the single memory port of the SwiVM arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface swivm_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              i_p0_req;
  logic              i_p0_we;
  logic [1:0]        i_p0_size;
  logic [ADDR_W-1:0] i_p0_addr;
  logic [DATA_W-1:0] i_p0_wdata;
  logic              o_p0_ack;
  logic [DATA_W-1:0] o_p0_rdata;

  logic              i_p1_req;
  logic              i_p1_we;
  logic [1:0]        i_p1_size;
  logic [ADDR_W-1:0] i_p1_addr;
  logic [DATA_W-1:0] i_p1_wdata;
  logic              o_p1_ack;
  logic [DATA_W-1:0] o_p1_rdata;

  logic [ADDR_W-1:0] o_m_addr;
  logic [DATA_W-1:0] o_m_wrdata;
  logic [1:0]        o_m_size;
  logic              o_m_we;
  logic [DATA_W-1:0] i_m_rddata;

  modport slave (
    input  i_p0_req, i_p0_we, i_p0_size, i_p0_addr, i_p0_wdata,
    output o_p0_ack, o_p0_rdata,
    input  i_p1_req, i_p1_we, i_p1_size, i_p1_addr, i_p1_wdata,
    output o_p1_ack, o_p1_rdata,
    output o_m_addr, o_m_wrdata, o_m_size, o_m_we,
    input  i_m_rddata
  );

  modport master (
    output i_p0_req, i_p0_we, i_p0_size, i_p0_addr, i_p0_wdata,
    input  o_p0_ack, o_p0_rdata,
    output i_p1_req, i_p1_we, i_p1_size, i_p1_addr, i_p1_wdata,
    input  o_p1_ack, o_p1_rdata,
    input  o_m_addr, o_m_wrdata, o_m_size, o_m_we,
    output i_m_rddata
  );
endinterface

// File: rtl/swivm_mem_arbiter.sv
// Round-robin two-port arbiter in front of the SwiVM memory; each access takes a grant edge
// plus a completion edge, ack is a one-cycle pulse, and a port is ignored while its ack is high.
module swivm_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  swivm_mem_arbiter_if.slave     bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              cur_q, cur_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wrdata_q, m_wrdata_d;
  logic [1:0]        m_size_q, m_size_d;
  logic              m_we_q, m_we_d;
  logic              p0_ack_q, p0_ack_d;
  logic              p1_ack_q, p1_ack_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

  logic              elig0, elig1;
  logic              grant_vld;
  logic              grant_port;

  // A port whose ack is currently high is treated as not requesting.
  always_comb begin
    elig0      = bus.i_p0_req & ~p0_ack_q;
    elig1      = bus.i_p1_req & ~p1_ack_q;
    grant_vld  = elig0 | elig1;
    grant_port = (elig0 & elig1) ? ~last_grant_q : elig1;
  end

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    last_grant_d = last_grant_q;
    m_addr_d     = m_addr_q;
    m_wrdata_d   = m_wrdata_q;
    m_size_d     = m_size_q;
    m_we_d       = m_we_q;
    p0_ack_d     = 1'b0;
    p1_ack_d     = 1'b0;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;

    case (state_q)
      ST_IDLE: begin
        m_we_d = 1'b1;
        if (grant_vld) begin
          if (grant_port) begin
            m_addr_d   = bus.i_p1_addr;
            m_wrdata_d = bus.i_p1_wdata;
            m_size_d   = bus.i_p1_size;
            m_we_d     = bus.i_p1_we;
          end else begin
            m_addr_d   = bus.i_p0_addr;
            m_wrdata_d = bus.i_p0_wdata;
            m_size_d   = bus.i_p0_size;
            m_we_d     = bus.i_p0_we;
          end
          cur_d        = grant_port;
          last_grant_d = grant_port;
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // m_we_q still holds the in-flight direction: high means a read.
        if (cur_q) begin
          p1_ack_d = 1'b1;
          if (m_we_q) p1_rdata_d = bus.i_m_rddata;
        end else begin
          p0_ack_d = 1'b1;
          if (m_we_q) p0_rdata_d = bus.i_m_rddata;
        end
        m_we_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        m_we_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      cur_q        <= 1'b0;
      last_grant_q <= 1'b1;
      m_addr_q     <= '0;
      m_wrdata_q   <= '0;
      m_size_q     <= 2'b11;
      m_we_q       <= 1'b1;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      last_grant_q <= last_grant_d;
      m_addr_q     <= m_addr_d;
      m_wrdata_q   <= m_wrdata_d;
      m_size_q     <= m_size_d;
      m_we_q       <= m_we_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

  assign bus.o_m_addr   = m_addr_q;
  assign bus.o_m_wrdata = m_wrdata_q;
  assign bus.o_m_size   = m_size_q;
  assign bus.o_m_we     = m_we_q;
  assign bus.o_p0_ack   = p0_ack_q;
  assign bus.o_p1_ack   = p1_ack_q;
  assign bus.o_p0_rdata = p0_rdata_q;
  assign bus.o_p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_swivm_mem_arbiter.sv
// Bench for swivm_mem_arbiter: byte-addressed memory model on the memory port, a
// transaction-level reference of the arbiter, directed scenarios and a random phase.
module tb_swivm_mem_arbiter;

  logic i_clk;
  logic i_rst_n;

  swivm_mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  swivm_mem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory attached to the arbiter ----------------
  logic [7:0] env_mem [65536];
  logic [7:0] ref_mem [65536];

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b10) ? 2 : 4;
  endfunction

  function automatic logic [31:0] env_read(input logic [15:0] a, input logic [1:0] sz);
    logic [31:0] v = '0;
    for (int i = 0; i < nbytes(sz); i++) v[8*i +: 8] = env_mem[a + 16'(i)];
    return v;
  endfunction

  function automatic logic [31:0] ref_read(input logic [15:0] a, input logic [1:0] sz);
    logic [31:0] v = '0;
    for (int i = 0; i < nbytes(sz); i++) v[8*i +: 8] = ref_mem[a + 16'(i)];
    return v;
  endfunction

  task automatic ref_write(input logic [15:0] a, input logic [1:0] sz, input logic [31:0] d);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[a + 16'(i)] = d[8*i +: 8];
  endtask

  logic        wr_pend;
  logic [15:0] wr_addr;
  logic [1:0]  wr_size;
  logic [31:0] wr_data;

  // Memory samples the bus mid-cycle: read data ready for the next edge, write committed at it.
  initial begin
    bus.i_m_rddata = '0;
    wr_pend = 1'b0;
    wr_addr = '0;
    wr_size = '0;
    wr_data = '0;
    forever begin
      @(negedge i_clk);
      bus.i_m_rddata = env_read(bus.o_m_addr, bus.o_m_size);
      wr_pend = !bus.o_m_we;
      wr_addr = bus.o_m_addr;
      wr_size = bus.o_m_size;
      wr_data = bus.o_m_wrdata;
    end
  end

  initial begin
    forever begin
      @(posedge i_clk);
      if (wr_pend && i_rst_n)
        for (int i = 0; i < nbytes(wr_size); i++) env_mem[wr_addr + 16'(i)] = wr_data[8*i +: 8];
    end
  end

  // ---------------- transaction-level reference ----------------
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [15:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic [15:0] e_addr;
  logic [31:0] e_wr;
  logic [1:0]  e_size;
  logic        e_we;
  logic        e_ack [2];
  logic [31:0] e_rd  [2];
  bit          in_flight;
  int          owner;
  int          last_winner;
  txn_t        txn;

  function automatic txn_t take(input int p);
    txn_t t;
    t.we    = p ? bus.i_p1_we    : bus.i_p0_we;
    t.size  = p ? bus.i_p1_size  : bus.i_p0_size;
    t.addr  = p ? bus.i_p1_addr  : bus.i_p0_addr;
    t.wdata = p ? bus.i_p1_wdata : bus.i_p0_wdata;
    return t;
  endfunction

  task automatic model_step();
    bit want [2];
    int pick;
    if (!i_rst_n) begin
      e_addr = '0; e_wr = '0; e_size = 2'b11; e_we = 1'b1;
      e_ack[0] = 1'b0; e_ack[1] = 1'b0; e_rd[0] = '0; e_rd[1] = '0;
      in_flight = 1'b0; owner = 0; last_winner = 1;
    end else if (in_flight) begin
      e_ack[owner]     = 1'b1;
      e_ack[1 - owner] = 1'b0;
      if (txn.we) e_rd[owner] = ref_read(txn.addr, txn.size);
      else        ref_write(txn.addr, txn.size, txn.wdata);
      e_we = 1'b1;
      in_flight = 1'b0;
    end else begin
      want[0] = bus.i_p0_req && !e_ack[0];
      want[1] = bus.i_p1_req && !e_ack[1];
      e_ack[0] = 1'b0;
      e_ack[1] = 1'b0;
      pick = -1;
      if (want[0] && want[1]) pick = 1 - last_winner;
      else if (want[0])       pick = 0;
      else if (want[1])       pick = 1;
      if (pick >= 0) begin
        txn = take(pick);
        e_addr = txn.addr; e_wr = txn.wdata; e_size = txn.size; e_we = txn.we;
        owner = pick; last_winner = pick; in_flight = 1'b1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge i_clk or negedge i_rst_n);
      model_step();
    end
  end

  bit cmp_en = 1'b1;

  initial begin
    forever begin
      @(negedge i_clk);
      if (cmp_en) begin
        check("m_addr",   32'(bus.o_m_addr),   32'(e_addr));
        check("m_wrdata", bus.o_m_wrdata,      e_wr);
        check("m_size",   32'(bus.o_m_size),   32'(e_size));
        check("m_we",     32'(bus.o_m_we),     32'(e_we));
        check("p0_ack",   32'(bus.o_p0_ack),   32'(e_ack[0]));
        check("p1_ack",   32'(bus.o_p1_ack),   32'(e_ack[1]));
        check("p0_rdata", bus.o_p0_rdata,      e_rd[0]);
        check("p1_rdata", bus.o_p1_rdata,      e_rd[1]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge i_clk);
    #2;
  endtask

  task automatic set_req(input int p, input logic r, input logic we, input logic [1:0] sz,
                         input logic [15:0] a, input logic [31:0] wd);
    if (p == 0) begin
      bus.i_p0_req = r; bus.i_p0_we = we; bus.i_p0_size = sz; bus.i_p0_addr = a; bus.i_p0_wdata = wd;
    end else begin
      bus.i_p1_req = r; bus.i_p1_we = we; bus.i_p1_size = sz; bus.i_p1_addr = a; bus.i_p1_wdata = wd;
    end
  endtask

  task automatic xact(input int p, input logic we, input logic [1:0] sz, input logic [15:0] a,
                      input logic [31:0] wd, output logic g_we, output logic [1:0] g_sz,
                      output logic [15:0] g_addr, output logic ackv, output logic [31:0] rd);
    set_req(p, 1'b1, we, sz, a, wd);
    step();
    g_we = bus.o_m_we; g_sz = bus.o_m_size; g_addr = bus.o_m_addr;
    set_req(p, 1'b0, 1'b1, 2'b11, 16'h0, 32'h0);
    step();
    ackv = p ? bus.o_p1_ack : bus.o_p0_ack;
    rd   = p ? bus.o_p1_rdata : bus.o_p0_rdata;
    step();
  endtask

  function automatic logic [1:0] rand_size();
    int k = $urandom_range(0, 2);
    return (k == 0) ? 2'b00 : (k == 1) ? 2'b10 : 2'b11;
  endfunction

  logic        g_we, ackv;
  logic [1:0]  g_sz;
  logic [15:0] g_addr;
  logic [31:0] rd;
  int          ack_cnt;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      env_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    {env_mem[16'h0013], env_mem[16'h0012], env_mem[16'h0011], env_mem[16'h0010]} = 32'h12345678;
    {env_mem[16'h0203], env_mem[16'h0202], env_mem[16'h0201], env_mem[16'h0200]} = 32'h11223344;
    {env_mem[16'h0007], env_mem[16'h0006], env_mem[16'h0005], env_mem[16'h0004]} = 32'h44332211;
    {env_mem[16'h000B], env_mem[16'h000A], env_mem[16'h0009], env_mem[16'h0008]} = 32'h88776655;
    for (int i = 0; i < 65536; i++) ref_mem[i] = env_mem[i];

    i_rst_n = 1'b0;
    set_req(0, 1'b0, 1'b1, 2'b11, 16'h0, 32'h0);
    set_req(1, 1'b0, 1'b1, 2'b11, 16'h0, 32'h0);
    #7;
    check("rst_m_we",   32'(bus.o_m_we),   32'h1);
    check("rst_m_addr", 32'(bus.o_m_addr), 32'h0);
    check("rst_m_size", 32'(bus.o_m_size), 32'h3);
    check("rst_acks",   32'({bus.o_p0_ack, bus.o_p1_ack}), 32'h0);
    check("rst_rdata",  bus.o_p0_rdata | bus.o_p1_rdata, 32'h0);
    step();
    i_rst_n = 1'b1;
    step();

    // P0 word read
    xact(0, 1'b1, 2'b11, 16'h0010, 32'h0, g_we, g_sz, g_addr, ackv, rd);
    check("t1_grant_addr", 32'(g_addr), 32'h0010);
    check("t1_grant_we",   32'(g_we),   32'h1);
    check("t1_ack",        32'(ackv),   32'h1);
    check("t1_rdata",      rd,          32'h12345678);
    check("t1_ack_low",    32'(bus.o_p0_ack), 32'h0);

    // P1 byte write then word read back
    xact(1, 1'b0, 2'b00, 16'h0100, 32'hDEADBEEF, g_we, g_sz, g_addr, ackv, rd);
    check("t2_grant_we",   32'(g_we), 32'h0);
    check("t2_grant_size", 32'(g_sz), 32'h0);
    check("t2_ack",        32'(ackv), 32'h1);
    check("t2_rdata_held", rd,        32'h0);
    check("t2_we_back",    32'(bus.o_m_we), 32'h1);
    xact(1, 1'b1, 2'b11, 16'h0100, 32'h0, g_we, g_sz, g_addr, ackv, rd);
    check("t2_readback",   rd, 32'h000000EF);

    // Both ports requesting continuously from reset
    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1;
    set_req(0, 1'b1, 1'b1, 2'b11, 16'h0010, 32'h0);
    set_req(1, 1'b1, 1'b1, 2'b11, 16'h0100, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("t3_p0_ack_%0d", i), 32'(bus.o_p0_ack), (i == 2 || i == 6) ? 32'h1 : 32'h0);
      check($sformatf("t3_p1_ack_%0d", i), 32'(bus.o_p1_ack), (i == 4 || i == 8) ? 32'h1 : 32'h0);
    end
    set_req(0, 1'b0, 1'b1, 2'b11, 16'h0, 32'h0);
    set_req(1, 1'b0, 1'b1, 2'b11, 16'h0, 32'h0);
    step();
    step();

    // P0 holds its request for ten edges
    ack_cnt = 0;
    set_req(0, 1'b1, 1'b1, 2'b11, 16'h0010, 32'h0);
    for (int i = 1; i <= 12; i++) begin
      if (i == 11) set_req(0, 1'b0, 1'b1, 2'b11, 16'h0, 32'h0);
      step();
      if (bus.o_p0_ack) ack_cnt++;
    end
    check("t4_ack_count", 32'(ack_cnt), 32'd4);

    // Reset while a P1 write is in flight
    set_req(1, 1'b1, 1'b0, 2'b11, 16'h0200, 32'hCAFEF00D);
    step();
    check("t5_grant_we", 32'(bus.o_m_we), 32'h0);
    set_req(1, 1'b0, 1'b1, 2'b11, 16'h0, 32'h0);
    #1 i_rst_n = 1'b0;
    #1;
    check("t5_we_abort", 32'(bus.o_m_we),   32'h1);
    check("t5_no_ack",   32'(bus.o_p1_ack), 32'h0);
    step();
    check("t5_no_ack_2", 32'(bus.o_p1_ack), 32'h0);
    i_rst_n = 1'b1;
    step();
    xact(1, 1'b1, 2'b11, 16'h0200, 32'h0, g_we, g_sz, g_addr, ackv, rd);
    check("t5_preserved", rd, 32'h11223344);

    // Address change while busy has no effect
    set_req(0, 1'b1, 1'b1, 2'b11, 16'h0004, 32'h0);
    step();
    check("t6_grant_addr", 32'(bus.o_m_addr), 32'h0004);
    set_req(0, 1'b0, 1'b1, 2'b11, 16'h0008, 32'h0);
    step();
    check("t6_ack",        32'(bus.o_p0_ack),   32'h1);
    check("t6_rdata",      bus.o_p0_rdata,      32'h44332211);
    check("t6_addr_held",  32'(bus.o_m_addr),   32'h0004);
    step();

    // Random traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
      end
      for (int p = 0; p < 2; p++)
        if ($urandom_range(0, 2) == 0)
          set_req(p, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rand_size(),
                  16'($urandom_range(0, 63)), $urandom);
      step();
    end
    set_req(0, 1'b0, 1'b1, 2'b11, 16'h0, 32'h0);
    set_req(1, 1'b0, 1'b1, 2'b11, 16'h0, 32'h0);
    step();
    step();
    step();

    // Final memory image must match the reference image over the random window
    for (int a = 0; a < 72; a++)
      check($sformatf("mem_%0d", a), 32'(env_mem[a]), 32'(ref_mem[a]));

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
